giraffe_capture_sequencer: RTL and testbench
============================================

// Module: giraffe_capture_sequencer
// PURPOSE
//  Command-driven sequencer for the Giraffe ADC test chip: chip reset -> calibration -> capture -> UART readout.
//  Sits between the UART rx command decoder, the ADC ack edge trigger, and the UART tx.
//  Stores NUM_SAMPLES conversion words in an on-chip buffer, then streams them one byte per sample.
// PARAMETERS
//  NUM_bit       6     ADC output word width (<= UART_NUM_DATA)
//  NUM_SAMPLES   1024  samples captured per run
//  NUM_CALIB     1000  adc_trigger pulses spent in calibration
//  RST_CYCLES    16    clk cycles adc_rstn is held low
//  UART_NUM_DATA 8     UART byte width
//  CMDLENGTH     4     command code width
// PORTS
//  clk           in   1              system clock
//  nrst          in   1              reset, synchronous, active-low
//  pll_locked    in   1              low = behave as reset
//  cmd           in   CMDLENGTH      decoded UART command
//  cmd_vld       in   1              1-cycle strobe, cmd valid
//  sw_NOWA       in   9              NOWA setting, sampled at START/CAPTURE accept
//  adc_trigger   in   1              1-cycle pulse per ADC conversion (ack|ack_sub rising edge)
//  adc_dout      in   NUM_bit        ADC word, valid with adc_trigger
//  adc_rstn      out  1              chip reset, active-low
//  adc_calib_ena out  1              chip calibration enable
//  adc_ena       out  1              chip conversion enable
//  adc_NOWA      out  9              latched NOWA to chip
//  uart_wdata    out  UART_NUM_DATA  tx byte = zero-extended sample
//  uart_wreq     out  1              tx request; transfer when uart_wreq & uart_rdy
//  uart_rdy      in   1              tx ready
//  busy          out  1              state != IDLE
//  state         out  4              current state encoding (LED)
//  cnt_received  out  18             samples stored this run (LED)
// BEHAVIOUR
//  Reset (nrst=0 at clk edge, or pll_locked=0): state=IDLE, adc_rstn=1, adc_calib_ena=0, adc_ena=0,
//   adc_NOWA=0, uart_wdata=0, uart_wreq=0, busy=0, cnt_received=0. Buffer contents undefined.
//  Commands (IDLE only; otherwise ignored except ABORT): 4'h1 START -> RST; 4'h2 CAPTURE -> CAP;
//   4'h3 SEND -> SEND; 4'hF ABORT; other codes ignored. START/CAPTURE latch sw_NOWA and clear cnt_received.
//  States: IDLE=0, RST=1, CAL=2, CAP=3, SEND=4.
//   RST: adc_rstn=0 for exactly RST_CYCLES cycles, then CAL.
//   CAL: adc_calib_ena=1; after NUM_CALIB adc_trigger pulses, next cycle -> CAP (calib_ena drops same edge).
//   CAP: adc_ena=1; each adc_trigger writes adc_dout at addr cnt_received, cnt_received++.
//    On the edge storing sample NUM_SAMPLES: adc_ena=0 registered that edge, state -> SEND.
//    Triggers outside CAP never write and never count.
//   SEND: sends cnt_received bytes, addr 0 upward. Buffer read latency 1 cycle: first uart_wreq
//    2 cycles after SEND entry; after each transfer (wreq&rdy), wreq drops 1 cycle (read bubble)
//    then reasserts with the next byte. wdata stable while wreq high. After last transfer -> IDLE.
//    SEND with cnt_received=0 -> IDLE next cycle, no wreq.
//  ABORT (cmd_vld & cmd=4'hF) in any state: next edge IDLE, adc_rstn=1, calib_ena/ena/wreq=0;
//   cnt_received and buffer retained (a later SEND reads the partial capture).
//  ABORT simultaneous with the last-sample trigger: ABORT wins, sample is still stored and counted.
//  Counters: sample counter $clog2(NUM_SAMPLES+1) bits, zero-extended to 18 bits; calib counter
//   $clog2(NUM_CALIB+1) bits; rst counter $clog2(RST_CYCLES+1) bits. No wrap possible.
// STRUCTURE
//  giraffe_pkg: command codes (CMD_START/CAPTURE/SEND/ABORT), state encodings.
//  Sub-module giraffe_sample_ram: simple dual-port, NUM_SAMPLES x NUM_bit, sync write, 1-cycle
//   registered read, inferred block RAM, no reset.
//  Top: FSM, counters, NOWA latch, tx handshake register stage.
// TESTING (bench params: RST_CYCLES=4, NUM_CALIB=3, NUM_SAMPLES=8)
//  START, sw_NOWA=9'h1A5, 3 calib triggers then 8 triggers dout=0..7 -> adc_rstn low 4 cycles,
//   calib_ena high until 3rd pulse, adc_NOWA=9'h1A5, bytes 8'h00..8'h07 sent in order, end IDLE.
//  uart_rdy held low 20 cycles in SEND -> wreq held high, wdata unchanged, no byte lost/duplicated.
//  CAPTURE, 5 triggers, ABORT -> IDLE next edge, adc_ena=0, cnt_received=5;
//   then SEND -> exactly 5 bytes.
//  ABORT same cycle as 8th trigger -> IDLE, cnt_received=8, no wreq.
//  START while in CAP and unknown cmd 4'h7 in IDLE -> no state change.
//  nrst low mid-SEND (synchronous) -> all outputs at reset values next edge;
//   pll_locked low mid-CAL -> same.

Source files
------------

// File: rtl/giraffe_pkg.sv
// giraffe_pkg
// Shared definitions for the Giraffe ADC capture sequencer: UART command
// codes, FSM state encodings (these are also shown on the board LEDs) and
// the sub-phases used while streaming the sample buffer out over the UART.
package giraffe_pkg;

  // Command codes delivered by the UART rx command decoder
  localparam logic [3:0] CMD_START   = 4'h1;
  localparam logic [3:0] CMD_CAPTURE = 4'h2;
  localparam logic [3:0] CMD_SEND    = 4'h3;
  localparam logic [3:0] CMD_ABORT   = 4'hF;

  // Encodings are fixed because software and the LEDs decode them
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RST  = 4'd1,
    ST_CAL  = 4'd2,
    ST_CAP  = 4'd3,
    ST_SEND = 4'd4
  } state_t;

  // Readout pipeline: ISSUE presents the first read address, LOAD moves the
  // RAM output into the tx register, HOLD keeps the request up until taken
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_LOAD  = 2'd1,
    PH_HOLD  = 2'd2
  } send_phase_t;

endpackage

// File: rtl/giraffe_sample_ram.sv
// giraffe_sample_ram
// Simple dual-port sample buffer: synchronous write, registered read with
// one cycle of latency, no reset so that it maps onto block RAM.
// Ports:
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address (sampled every cycle)
//   rd_data  out  word at the rd_addr of the previous cycle
module giraffe_sample_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 6,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/giraffe_capture_sequencer.sv
// giraffe_capture_sequencer
// Command-driven sequencer for the Giraffe ADC test chip:
// chip reset -> calibration -> capture into the sample buffer -> UART readout.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   pll_locked         low forces the same state as reset
//   cmd, cmd_vld       decoded UART command and its 1-cycle strobe
//   sw_NOWA            NOWA setting, latched when START/CAPTURE is accepted
//   adc_trigger        1-cycle pulse per ADC conversion, adc_dout valid with it
//   adc_rstn           chip reset (active-low)
//   adc_calib_ena      chip calibration enable
//   adc_ena            chip conversion enable
//   adc_NOWA           latched NOWA value driven to the chip
//   uart_wdata/wreq    tx byte and request, transfer when uart_wreq & uart_rdy
//   uart_rdy           tx ready
//   busy, state        status for the LEDs
//   cnt_received       samples stored in the current run
module giraffe_capture_sequencer
  import giraffe_pkg::*;
#(
  parameter int NUM_bit       = 6,
  parameter int NUM_SAMPLES   = 1024,
  parameter int NUM_CALIB     = 1000,
  parameter int RST_CYCLES    = 16,
  parameter int UART_NUM_DATA = 8,
  parameter int CMDLENGTH     = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     pll_locked,
  input  logic [CMDLENGTH-1:0]     cmd,
  input  logic                     cmd_vld,
  input  logic [8:0]               sw_NOWA,
  input  logic                     adc_trigger,
  input  logic [NUM_bit-1:0]       adc_dout,
  output logic                     adc_rstn,
  output logic                     adc_calib_ena,
  output logic                     adc_ena,
  output logic [8:0]               adc_NOWA,
  output logic [UART_NUM_DATA-1:0] uart_wdata,
  output logic                     uart_wreq,
  input  logic                     uart_rdy,
  output logic                     busy,
  output logic [3:0]               state,
  output logic [17:0]              cnt_received
);

  localparam int SCW = $clog2(NUM_SAMPLES + 1);
  localparam int AW  = $clog2(NUM_SAMPLES);
  localparam int CCW = $clog2(NUM_CALIB + 1);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  state_t           state_q, state_d;
  send_phase_t      send_phase;
  logic [SCW-1:0]   sample_cnt;
  logic [SCW-1:0]   send_idx;
  logic [CCW-1:0]   calib_cnt;
  logic [RCW-1:0]   rst_cnt;
  logic [AW-1:0]    rd_addr;
  logic [NUM_bit-1:0] rd_data;

  logic sync_rst, cmd_abort, idle_cmd, accept_run;
  logic cap_write, last_sample, calib_done, rst_done, tx_fire, send_last;

  // A lost PLL is treated exactly like a reset request
  assign sync_rst    = !nrst || !pll_locked;
  assign cmd_abort   = cmd_vld && (cmd == CMD_ABORT);
  assign idle_cmd    = cmd_vld && (state_q == ST_IDLE);
  assign accept_run  = idle_cmd && ((cmd == CMD_START) || (cmd == CMD_CAPTURE));
  // Capture writes do not look at ABORT: a simultaneous last sample is kept
  assign cap_write   = (state_q == ST_CAP) && adc_trigger;
  assign last_sample = cap_write && (sample_cnt == SCW'(NUM_SAMPLES - 1));
  assign calib_done  = (state_q == ST_CAL) && adc_trigger && (calib_cnt == CCW'(NUM_CALIB - 1));
  assign rst_done    = (state_q == ST_RST) && (rst_cnt == RCW'(RST_CYCLES - 1));
  assign tx_fire     = uart_wreq && uart_rdy;
  assign send_last   = (send_idx + SCW'(1)) == sample_cnt;

  // While a byte waits in HOLD the next address is prefetched, so after a
  // transfer only a single bubble cycle is needed before the next request
  assign rd_addr = AW'(send_idx) + AW'(send_phase == PH_HOLD);

  giraffe_sample_ram #(
    .DEPTH (NUM_SAMPLES),
    .WIDTH (NUM_bit)
  ) u_ram (
    .clk     (clk),
    .wr_en   (cap_write),
    .wr_addr (AW'(sample_cnt)),
    .wr_data (adc_dout),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ABORT overrides everything else
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_cmd) begin
          case (cmd)
            CMD_START:   state_d = ST_RST;
            CMD_CAPTURE: state_d = ST_CAP;
            CMD_SEND:    state_d = ST_SEND;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_RST:  if (rst_done)    state_d = ST_CAL;
      ST_CAL:  if (calib_done)  state_d = ST_CAP;
      ST_CAP:  if (last_sample) state_d = ST_SEND;
      ST_SEND: begin
        if (sample_cnt == '0) begin
          state_d = ST_IDLE;
        end else if (tx_fire && send_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_abort) begin
      state_d = ST_IDLE;
    end
  end

  // Chip controls are decoded from the registered state so they change on
  // the same edge as the state itself
  always_comb begin
    adc_rstn      = 1'b1;
    adc_calib_ena = 1'b0;
    adc_ena       = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_RST:  adc_rstn      = 1'b0;
      ST_CAL:  adc_calib_ena = 1'b1;
      ST_CAP:  adc_ena       = 1'b1;
      default: ;
    endcase
  end

  // Counters, NOWA latch and the tx handshake register stage
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sample_cnt <= '0;
      adc_NOWA   <= '0;
      rst_cnt    <= '0;
      calib_cnt  <= '0;
      send_idx   <= '0;
      send_phase <= PH_ISSUE;
      uart_wdata <= '0;
      uart_wreq  <= 1'b0;
    end else begin
      if (accept_run) begin
        adc_NOWA   <= sw_NOWA;
        sample_cnt <= '0;
      end else if (cap_write) begin
        sample_cnt <= sample_cnt + SCW'(1);
      end

      rst_cnt <= (state_q == ST_RST) ? rst_cnt + RCW'(1) : '0;

      if (state_q != ST_CAL) begin
        calib_cnt <= '0;
      end else if (adc_trigger) begin
        calib_cnt <= calib_cnt + CCW'(1);
      end

      if ((state_q != ST_SEND) || cmd_abort) begin
        send_idx   <= '0;
        send_phase <= PH_ISSUE;
        uart_wreq  <= 1'b0;
      end else begin
        case (send_phase)
          PH_ISSUE: send_phase <= PH_LOAD;
          PH_LOAD: begin
            uart_wdata <= UART_NUM_DATA'(rd_data);
            uart_wreq  <= 1'b1;
            send_phase <= PH_HOLD;
          end
          PH_HOLD: begin
            if (tx_fire) begin
              uart_wreq  <= 1'b0;
              send_idx   <= send_idx + SCW'(1);
              send_phase <= PH_LOAD;
            end
          end
          default: send_phase <= PH_ISSUE;
        endcase
      end
    end
  end

  assign state        = state_q;
  assign cnt_received = 18'(sample_cnt);

endmodule

// File: tb/tb_giraffe_capture_sequencer.sv
// tb_giraffe_capture_sequencer
// Directed bench for the capture sequencer with a small configuration
// (RST_CYCLES=4, NUM_CALIB=3, NUM_SAMPLES=8). A table of per-cycle vectors
// walks the START flow; hand-written sequences cover readout handshaking,
// ABORT corner cases and the two reset sources.
module tb_giraffe_capture_sequencer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        pll_locked;
  logic [3:0]  cmd;
  logic        cmd_vld;
  logic [8:0]  sw_NOWA;
  logic        adc_trigger;
  logic [5:0]  adc_dout;
  logic        adc_rstn;
  logic        adc_calib_ena;
  logic        adc_ena;
  logic [8:0]  adc_NOWA;
  logic [7:0]  uart_wdata;
  logic        uart_wreq;
  logic        uart_rdy;
  logic        busy;
  logic [3:0]  state;
  logic [17:0] cnt_received;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic        vld;
    logic [3:0]  cmd;
    logic        trig;
    logic [5:0]  dout;
    logic [3:0]  st;
    logic        rstn;
    logic        cal;
    logic        ena;
    logic [17:0] cnt;
  } vec_t;

  vec_t vecs[$];

  giraffe_capture_sequencer #(
    .NUM_bit       (6),
    .NUM_SAMPLES   (8),
    .NUM_CALIB     (3),
    .RST_CYCLES    (4),
    .UART_NUM_DATA (8),
    .CMDLENGTH     (4)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .pll_locked    (pll_locked),
    .cmd           (cmd),
    .cmd_vld       (cmd_vld),
    .sw_NOWA       (sw_NOWA),
    .adc_trigger   (adc_trigger),
    .adc_dout      (adc_dout),
    .adc_rstn      (adc_rstn),
    .adc_calib_ena (adc_calib_ena),
    .adc_ena       (adc_ena),
    .adc_NOWA      (adc_NOWA),
    .uart_wdata    (uart_wdata),
    .uart_wreq     (uart_wreq),
    .uart_rdy      (uart_rdy),
    .busy          (busy),
    .state         (state),
    .cnt_received  (cnt_received)
  );

  always #5 clk = ~clk;

  // Hard stop in case something stalls the main sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic vld, input logic [3:0] c, input logic trig,
                                 input logic [5:0] d, input logic [3:0] st, input logic rstn,
                                 input logic cal, input logic ena, input logic [17:0] cnt);
    vec_t v;
    v.vld = vld; v.cmd = c; v.trig = trig; v.dout = d;
    v.st = st; v.rstn = rstn; v.cal = cal; v.ena = ena; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    cmd_vld     = v.vld;
    cmd         = v.cmd;
    adc_trigger = v.trig;
    adc_dout    = v.dout;
    step();
    cmd_vld     = 1'b0;
    adc_trigger = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp($sformatf("vec%0d_state", idx), 32'(state), 32'(v.st));
    cmp($sformatf("vec%0d_rstn", idx), 32'(adc_rstn), 32'(v.rstn));
    cmp($sformatf("vec%0d_calib", idx), 32'(adc_calib_ena), 32'(v.cal));
    cmp($sformatf("vec%0d_ena", idx), 32'(adc_ena), 32'(v.ena));
    cmp($sformatf("vec%0d_cnt", idx), 32'(cnt_received), 32'(v.cnt));
    cmp($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.st != 4'd0));
    cmp($sformatf("vec%0d_wreq", idx), 32'(uart_wreq), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_state"}, 32'(state), 32'd0);
    cmp({tag, "_rstn"}, 32'(adc_rstn), 32'd1);
    cmp({tag, "_calib"}, 32'(adc_calib_ena), 32'd0);
    cmp({tag, "_ena"}, 32'(adc_ena), 32'd0);
    cmp({tag, "_nowa"}, 32'(adc_NOWA), 32'd0);
    cmp({tag, "_wdata"}, 32'(uart_wdata), 32'd0);
    cmp({tag, "_wreq"}, 32'(uart_wreq), 32'd0);
    cmp({tag, "_busy"}, 32'(busy), 32'd0);
    cmp({tag, "_cnt"}, 32'(cnt_received), 32'd0);
  endtask

  task automatic sendCmd(input logic [3:0] c);
    cmd_vld = 1'b1;
    cmd     = c;
    step();
    cmd_vld = 1'b0;
    cmd     = 4'h0;
  endtask

  task automatic pulseTrigger(input logic [5:0] d);
    adc_trigger = 1'b1;
    adc_dout    = d;
    step();
    adc_trigger = 1'b0;
  endtask

  // Called in the first cycle of SEND; expects bytes base, base+1, ...
  task automatic collectBytes(input int n, input logic [7:0] base, input int hold_low);
    int got;
    int low_left;
    int extra;
    bit fire;
    bit bubble;
    got = 0;
    low_left = hold_low;
    bubble = 0;
    uart_rdy = 1'b0;
    cmp("send_entry_state", 32'(state), 32'd4);
    cmp("wreq_cycle0", 32'(uart_wreq), 32'd0);
    step();
    cmp("wreq_cycle1", 32'(uart_wreq), 32'd0);
    step();
    cmp("wreq_cycle2", 32'(uart_wreq), 32'd1);
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      if (low_left > 0) begin
        uart_rdy = 1'b0;
        cmp("hold_wreq", 32'(uart_wreq), 32'd1);
        cmp("hold_wdata", 32'(uart_wdata), 32'(base));
        low_left--;
      end else begin
        uart_rdy = 1'b1;
      end
      fire = uart_wreq && uart_rdy;
      if (fire) begin
        cmp($sformatf("byte%0d", got), 32'(uart_wdata), 32'(base) + 32'(got));
        got++;
      end
      step();
      if (fire && got < n) begin
        cmp("bubble_wreq", 32'(uart_wreq), 32'd0);
        bubble = 1;
      end else if (bubble) begin
        cmp("reassert_wreq", 32'(uart_wreq), 32'd1);
        bubble = 0;
      end
    end
    cmp("byte_count", 32'(got), 32'(n));
    cmp("send_end_state", 32'(state), 32'd0);
    extra = 0;
    uart_rdy = 1'b1;
    repeat (4) begin
      if (uart_wreq) extra++;
      step();
    end
    cmp("no_extra_wreq", 32'(extra), 32'd0);
    uart_rdy = 1'b0;
  endtask

  initial begin
    nrst        = 1'b0;
    pll_locked  = 1'b1;
    cmd         = 4'h0;
    cmd_vld     = 1'b0;
    sw_NOWA     = 9'h1A5;
    adc_trigger = 1'b0;
    adc_dout    = 6'h0;
    uart_rdy    = 1'b0;

    repeat (3) step();
    checkReset("por");
    nrst = 1'b1;

    // START flow: unknown code ignored, 4 reset cycles, 3 calib pulses,
    // START ignored in CAP, then 8 samples 0..7
    addVec(1, 4'h7, 0, 6'h00, 4'd0, 1, 0, 0, 18'd0);
    addVec(1, 4'h1, 0, 6'h00, 4'd1, 0, 0, 0, 18'd0);
    addVec(0, 4'h0, 0, 6'h00, 4'd1, 0, 0, 0, 18'd0);
    addVec(0, 4'h0, 0, 6'h00, 4'd1, 0, 0, 0, 18'd0);
    addVec(0, 4'h0, 0, 6'h00, 4'd1, 0, 0, 0, 18'd0);
    addVec(0, 4'h0, 0, 6'h00, 4'd2, 1, 1, 0, 18'd0);
    addVec(0, 4'h0, 1, 6'h3F, 4'd2, 1, 1, 0, 18'd0);
    addVec(0, 4'h0, 0, 6'h00, 4'd2, 1, 1, 0, 18'd0);
    addVec(0, 4'h0, 1, 6'h3E, 4'd2, 1, 1, 0, 18'd0);
    addVec(0, 4'h0, 1, 6'h3D, 4'd3, 1, 0, 1, 18'd0);
    addVec(1, 4'h1, 0, 6'h00, 4'd3, 1, 0, 1, 18'd0);
    for (int i = 0; i < 7; i++) begin
      addVec(0, 4'h0, 1, 6'(i), 4'd3, 1, 0, 1, 18'(i + 1));
    end
    addVec(0, 4'h0, 1, 6'd7, 4'd4, 1, 0, 0, 18'd8);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    cmp("start_nowa", 32'(adc_NOWA), 32'h1A5);
    collectBytes(8, 8'h00, 20);

    // Partial capture then ABORT; a later SEND reads exactly what was stored
    sw_NOWA = 9'h0C3;
    sendCmd(4'h2);
    cmp("cap_state", 32'(state), 32'd3);
    cmp("cap_nowa", 32'(adc_NOWA), 32'h0C3);
    cmp("cap_cnt_clear", 32'(cnt_received), 32'd0);
    for (int i = 0; i < 5; i++) pulseTrigger(6'h30 + 6'(i));
    sendCmd(4'hF);
    cmp("abort_state", 32'(state), 32'd0);
    cmp("abort_ena", 32'(adc_ena), 32'd0);
    cmp("abort_cnt", 32'(cnt_received), 32'd5);
    pulseTrigger(6'h3F);
    cmp("idle_trig_cnt", 32'(cnt_received), 32'd5);
    sendCmd(4'h3);
    collectBytes(5, 8'h30, 0);

    // ABORT in the same cycle as the last sample: ABORT wins, sample kept
    sw_NOWA = 9'h055;
    sendCmd(4'h2);
    for (int i = 0; i < 7; i++) pulseTrigger(6'h10 + 6'(i));
    adc_trigger = 1'b1;
    adc_dout    = 6'h17;
    cmd_vld     = 1'b1;
    cmd         = 4'hF;
    step();
    adc_trigger = 1'b0;
    cmd_vld     = 1'b0;
    cmd         = 4'h0;
    cmp("abort8_state", 32'(state), 32'd0);
    cmp("abort8_cnt", 32'(cnt_received), 32'd8);
    cmp("abort8_wreq", 32'(uart_wreq), 32'd0);
    cmp("abort8_ena", 32'(adc_ena), 32'd0);
    cmp("abort8_nowa", 32'(adc_NOWA), 32'h055);
    step();
    cmp("abort8_still_idle", 32'(state), 32'd0);
    sendCmd(4'h3);
    collectBytes(8, 8'h10, 0);

    // Synchronous nrst while a byte is pending
    sendCmd(4'h3);
    uart_rdy = 1'b0;
    step();
    step();
    cmp("pre_reset_wreq", 32'(uart_wreq), 32'd1);
    nrst = 1'b0;
    step();
    checkReset("nrst_send");
    nrst = 1'b1;

    // PLL loss during calibration
    sendCmd(4'h1);
    repeat (4) step();
    cmp("pre_pll_state", 32'(state), 32'd2);
    cmp("pre_pll_calib", 32'(adc_calib_ena), 32'd1);
    pll_locked = 1'b0;
    step();
    checkReset("pll_cal");
    pll_locked = 1'b1;
    step();
    cmp("post_pll_state", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
